// File: rtl/buffer_rd_arbiter.sv
// buffer_rd_arbiter
// Round-robin arbiter sharing one buffer read port between two requesters.
// Read data comes back one cycle after the grant. It is steered into a
// 2-entry response FIFO owned by the requester that issued the read.
// A per-requester credit (FIFO occupancy plus the read in flight) stops a
// FIFO from overflowing.
// Optional feature: define BUF_ARB_WR_FWD_EN for write-first forwarding. A
// read that hits the address being written in the same cycle then returns
// the new write data instead of the old buffer contents.
module buffer_rd_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data0,
    output logic [DATA_WIDTH-1:0] rsp_data1,
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_data_out,
    input  logic                  buf_valid_out,
    input  logic                  buf_wr_en,
    input  logic [ADDR_WIDTH-1:0] buf_wr_addr,
    input  logic [DATA_WIDTH-1:0] buf_wr_data
);

    // In-flight read and arbitration history
    logic                  if_valid_reg;
    logic                  if_tag_reg;
    logic                  last_grant_reg;
    logic [ADDR_WIDTH-1:0] addr_hold_reg;

    // Arbitration results for the current cycle
    logic [1:0]            eligible;
    logic [1:0]            pop;
    logic [1:0]            push;
    logic                  grant_any;
    logic                  grant_idx;
    logic [ADDR_WIDTH-1:0] req_addr_sel;
    logic [DATA_WIDTH-1:0] push_data;

    logic [1:0][DATA_WIDTH-1:0] head_data;

`ifdef BUF_ARB_WR_FWD_EN
    logic                  if_fwd_reg;
    logic [DATA_WIDTH-1:0] if_fwd_data_reg;
    logic                  fwd_hit;

    // A granted read colliding with a same-cycle write must return the new data
    assign fwd_hit   = grant_any & buf_wr_en & (buf_wr_addr == req_addr_sel);
    assign push_data = if_fwd_reg ? if_fwd_data_reg : buf_data_out;

    // Remember the colliding write data until the capture cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            if_fwd_reg      <= 1'b0;
            if_fwd_data_reg <= '0;
        end else begin
            if_fwd_reg <= fwd_hit;
            if (fwd_hit) begin
                if_fwd_data_reg <= buf_wr_data;
            end
        end
    end
`else
    // Without forwarding the write port is not observed; responses carry old contents
    logic unused_wr_snoop;
    assign unused_wr_snoop = ^{buf_wr_en, buf_wr_addr, buf_wr_data};
    assign push_data       = buf_data_out;
`endif

    // Per-requester credit check and 2-entry response FIFO with registered head
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic [1:0]            count_reg;
            logic [DATA_WIDTH-1:0] head_reg;
            logic [DATA_WIDTH-1:0] tail_reg;
            logic [2:0]            credit;

            assign rsp_valid[gi] = (count_reg != 2'd0) & ~rst;
            assign pop[gi]       = rsp_valid[gi] & rsp_ready[gi];
            // The read in flight for this requester is captured this very cycle
            assign push[gi]      = if_valid_reg & (if_tag_reg == 1'(gi));
            assign credit        = {1'b0, count_reg} + {2'b00, push[gi]} - {2'b00, pop[gi]};
            assign eligible[gi]  = req_valid[gi] & (credit < 3'd2) & ~rst;
            assign head_data[gi] = head_reg;

            // FIFO storage: head is the oldest entry, tail the second one
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= 2'd0;
                    head_reg  <= '0;
                    tail_reg  <= '0;
                end else begin
                    case ({push[gi], pop[gi]})
                        2'b10: begin
                            if (count_reg == 2'd0) begin
                                head_reg <= push_data;
                            end else begin
                                tail_reg <= push_data;
                            end
                            count_reg <= count_reg + 2'd1;
                        end
                        2'b01: begin
                            head_reg  <= tail_reg;
                            count_reg <= count_reg - 2'd1;
                        end
                        2'b11: begin
                            if (count_reg == 2'd1) begin
                                head_reg <= push_data;
                            end else begin
                                head_reg <= tail_reg;
                                tail_reg <= push_data;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

`ifndef SYNTHESIS
            // The credit rule must never let a push land in a full FIFO
            always_ff @(posedge clk) begin
                if (!rst) begin
                    assert (!(push[gi] && !pop[gi] && count_reg == 2'd2));
                end
            end
`endif
        end
    endgenerate

    assign rsp_data0 = head_data[0];
    assign rsp_data1 = head_data[1];

    // Same-cycle round-robin grant; on a tie the requester not granted last wins
    always_comb begin
        grant_any = |eligible;
        if (eligible == 2'b11) begin
            grant_idx = ~last_grant_reg;
        end else begin
            grant_idx = eligible[1];
        end
        req_addr_sel = grant_idx ? req_addr1 : req_addr0;
        req_ready    = 2'b00;
        if (grant_any) begin
            req_ready = grant_idx ? 2'b10 : 2'b01;
        end
        buf_rd_en   = grant_any;
        buf_rd_addr = grant_any ? req_addr_sel : addr_hold_reg;
    end

    // Track the read in flight, the last winner and the last driven address
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_reg   <= 1'b0;
            if_tag_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
            addr_hold_reg  <= '0;
        end else begin
            if_valid_reg <= grant_any;
            if_tag_reg   <= grant_idx;
            if (grant_any) begin
                last_grant_reg <= grant_idx;
                addr_hold_reg  <= req_addr_sel;
            end
        end
    end

`ifndef SYNTHESIS
    // Every capture cycle should coincide with valid read data from the buffer
    always_ff @(posedge clk) begin
        if (!rst && if_valid_reg) begin
            assert (buf_valid_out);
        end
    end
`endif

endmodule

// File: tb/tb_buffer_rd_arbiter.sv
// Testbench for buffer_rd_arbiter: behavioural buffer plus a queue-based
// reference model that predicts grants, response availability and data.
module tb_buffer_rd_arbiter;
    localparam int DW = 64;
    localparam int AW = 6;

`ifdef BUF_ARB_WR_FWD_EN
    localparam logic [DW-1:0] FWD_EXP = 64'hAAAA;
`else
    localparam logic [DW-1:0] FWD_EXP = 64'h1234;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst         = 1'b1;
    logic [1:0]    req_valid   = 2'b00;
    logic [AW-1:0] req_addr0   = '0;
    logic [AW-1:0] req_addr1   = '0;
    logic [1:0]    rsp_ready   = 2'b11;
    logic          buf_wr_en   = 1'b0;
    logic [AW-1:0] buf_wr_addr = '0;
    logic [DW-1:0] buf_wr_data = '0;
    logic          force_vout  = 1'b0;
    logic          vout_m      = 1'b0;
    logic [DW-1:0] buf_data_out = '0;
    wire  [1:0]    req_ready;
    wire  [1:0]    rsp_valid;
    wire  [DW-1:0] rsp_data0;
    wire  [DW-1:0] rsp_data1;
    wire           buf_rd_en;
    wire  [AW-1:0] buf_rd_addr;
    wire           buf_valid_out = vout_m | force_vout;

    int tests_run    = 0;
    int tests_failed = 0;

    buffer_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .buf_data_out(buf_data_out), .buf_valid_out(buf_valid_out),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data)
    );

    // Behavioural buffer: registered read, read-before-write on collision
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        vout_m <= buf_rd_en;
        if (buf_rd_en) buf_data_out <= mem[buf_rd_addr];
        if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
    end

    // Reference model: each requester owns a queue of accepted-but-unconsumed
    // reads, each with the value it must return and the cycle it becomes visible.
    logic [DW-1:0] exp_q [2][$];
    int            rdy_q [2][$];
    int            cyc    = 0;
    bit            m_last = 1'b1;
    logic [1:0]    m_vis, m_pop, m_elig, m_exp_ready;
    logic          m_gany;
    int            m_g, m_cnt;
    logic [AW-1:0] m_gaddr;
    logic [DW-1:0] m_gdata, m_rsp;

    always @(negedge clk) begin
        if (rst) begin
            tests_run++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || buf_rd_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL in_reset: req_ready=%b rsp_valid=%b rd_en=%b required 00/00/0",
                         req_ready, rsp_valid, buf_rd_en);
            end
            for (int i = 0; i < 2; i++) begin
                exp_q[i].delete();
                rdy_q[i].delete();
            end
            m_last = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_vis[i] = 1'b0;
                if (exp_q[i].size() > 0) m_vis[i] = (rdy_q[i][0] <= cyc);
                m_pop[i]  = m_vis[i] & rsp_ready[i];
                m_cnt     = exp_q[i].size() - int'(m_pop[i]);
                m_elig[i] = req_valid[i] && (m_cnt < 2);
            end
            m_gany = |m_elig;
            if (m_elig == 2'b11) m_g = m_last ? 0 : 1;
            else                 m_g = m_elig[1] ? 1 : 0;
            m_exp_ready = !m_gany ? 2'b00 : (m_g == 1 ? 2'b10 : 2'b01);
            m_gaddr     = (m_g == 1) ? req_addr1 : req_addr0;

            tests_run++;
            if (req_ready !== m_exp_ready) begin
                tests_failed++;
                $display("FAIL model_grant cyc %0d: req_ready=%b required %b", cyc, req_ready, m_exp_ready);
            end
            tests_run++;
            if (rsp_valid !== m_vis) begin
                tests_failed++;
                $display("FAIL model_rsp_valid cyc %0d: rsp_valid=%b required %b", cyc, rsp_valid, m_vis);
            end
            tests_run++;
            if (buf_rd_en !== m_gany) begin
                tests_failed++;
                $display("FAIL model_rd_en cyc %0d: buf_rd_en=%b required %b", cyc, buf_rd_en, m_gany);
            end
            if (m_gany) begin
                tests_run++;
                if (buf_rd_addr !== m_gaddr) begin
                    tests_failed++;
                    $display("FAIL model_rd_addr cyc %0d: buf_rd_addr=%0d required %0d", cyc, buf_rd_addr, m_gaddr);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (m_pop[i]) begin
                    m_rsp = (i == 0) ? rsp_data0 : rsp_data1;
                    tests_run++;
                    if (m_rsp !== exp_q[i][0]) begin
                        tests_failed++;
                        $display("FAIL model_rsp_data%0d cyc %0d: data=%h required %h", i, cyc, m_rsp, exp_q[i][0]);
                    end
                    void'(exp_q[i].pop_front());
                    void'(rdy_q[i].pop_front());
                end
            end
            if (m_gany) begin
                m_gdata = mem[m_gaddr];
`ifdef BUF_ARB_WR_FWD_EN
                if (buf_wr_en && buf_wr_addr == m_gaddr) m_gdata = buf_wr_data;
`endif
                exp_q[m_g].push_back(m_gdata);
                rdy_q[m_g].push_back(cyc + 2);
                m_last = (m_g == 1);
            end
        end
        cyc++;
    end

    task automatic idle();
        req_valid  = 2'b00;
        rsp_ready  = 2'b11;
        buf_wr_en  = 1'b0;
        force_vout = 1'b0;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // Fill the whole buffer through its write port; rnd selects random contents
    task automatic preload(input bit rnd);
        idle();
        for (int a = 0; a < 64; a++) begin
            buf_wr_en   = 1'b1;
            buf_wr_addr = AW'(a);
            buf_wr_data = rnd ? {$urandom, $urandom} : 64'(a + 100);
            @(posedge clk); #1;
        end
        buf_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        repeat (3) begin @(posedge clk); end
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b required 00", req_ready); end
        tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b required 00", rsp_valid); end
        tests_run++; if (buf_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b required 0", buf_rd_en); end
        tests_run++; if (buf_rd_addr !== '0) begin tests_failed++; $display("FAIL reset_rd_addr: got %0d required 0", buf_rd_addr); end
        tests_run++; if (rsp_data0 !== '0) begin tests_failed++; $display("FAIL reset_rsp_data0: got %h required 0", rsp_data0); end
        tests_run++; if (rsp_data1 !== '0) begin tests_failed++; $display("FAIL reset_rsp_data1: got %h required 0", rsp_data1); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_stream();
        preload(1'b0);
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 2'b01 : 2'b00;
            req_addr0 = AW'(k);
            rsp_ready = 2'b11;
            @(negedge clk);
            if (k < 8) begin
                tests_run++;
                if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL stream_ready k=%0d: got %b required 01", k, req_ready); end
            end
            if (k >= 2) begin
                tests_run++;
                if (rsp_valid[0] !== 1'b1 || rsp_data0 !== 64'(k + 98)) begin
                    tests_failed++;
                    $display("FAIL stream_data k=%0d: valid=%b data=%0d required 1/%0d", k, rsp_valid[0], rsp_data0, k + 98);
                end
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n1;
        n1 = 0;
        reset_dut();
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            req_addr0 = AW'($urandom);
            req_addr1 = AW'(k);
            @(negedge clk);
            if (req_ready[1]) n1++;
            if (k >= 4) begin
                tests_run++;
                if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_hold k=%0d: got %b required 01", k, req_ready); end
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (n1 != 2) begin tests_failed++; $display("FAIL bp_r1_grants: got %0d required 2", n1); end
        rsp_ready = 2'b11;
        req_addr1 = AW'(20);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL bp_regrant: got %b required 10", req_ready); end
        tests_run++;
        if (rsp_valid[1] !== 1'b1 || rsp_data1 !== 64'd101) begin
            tests_failed++; $display("FAIL bp_drain0: valid=%b data=%0d required 1/101", rsp_valid[1], rsp_data1);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        tests_run++;
        if (rsp_valid[1] !== 1'b1 || rsp_data1 !== 64'd103) begin
            tests_failed++; $display("FAIL bp_drain1: valid=%b data=%0d required 1/103", rsp_valid[1], rsp_data1);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_alternate();
        preload(1'b1);
        reset_dut();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 16; k++) begin
            req_addr0 = AW'($urandom);
            req_addr1 = AW'($urandom);
            @(negedge clk);
            tests_run++;
            if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                tests_failed++; $display("FAIL alternate k=%0d: got %b required %s", k, req_ready, (k % 2 == 0) ? "01" : "10");
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req_valid   = 2'($urandom_range(0, 3));
            req_addr0   = AW'($urandom);
            req_addr1   = AW'($urandom);
            rsp_ready   = 2'($urandom_range(0, 3));
            buf_wr_en   = ($urandom_range(0, 3) == 0);
            buf_wr_addr = ($urandom_range(0, 1) == 1) ? req_addr0 : AW'($urandom);
            buf_wr_data = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_fwd();
        buf_wr_en   = 1'b1;
        buf_wr_addr = AW'(5);
        buf_wr_data = 64'h1234;
        @(posedge clk); #1;
        req_valid   = 2'b01;
        req_addr0   = AW'(5);
        buf_wr_data = 64'hAAAA;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL fwd_grant: got %b required 01", req_ready); end
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (rsp_valid[0] !== 1'b1 || rsp_data0 !== FWD_EXP) begin
            tests_failed++; $display("FAIL fwd_data: valid=%b data=%h required 1/%h", rsp_valid[0], rsp_data0, FWD_EXP);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        repeat (6) begin @(posedge clk); #1; end
        rsp_ready = 2'b01;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_refill: got %b required 01", req_ready); end
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        req_valid  = 2'b00;
        force_vout = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL mid_after_rst: got %b required 00", rsp_valid); end
        @(posedge clk); #1;
        force_vout = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL mid_stale_push: got %b required 00", rsp_valid); end
        @(posedge clk); #1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_first_tie: got %b required 01", req_ready); end
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_backpressure();
        test_alternate();
        test_random();
        test_fwd();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/buffer_rd_arbiter.md
# buffer_rd_arbiter

Round-robin read arbiter that shares one `buffer` read port between two requesters (R0, R1) of the w4a8 GEMM datapath. It accepts address requests on valid/ready handshakes and drives the buffer's `rd_en`/`rd_addr`. It steers the 1-cycle-latency read data back to the owning requester through a 2-entry per-requester response FIFO with valid/ready backpressure. It sits between the buffer instance and the activation/weight fetch units; the buffer write port is not arbitrated and is only snooped.

## Interface
- `DATA_WIDTH`, 64, width of buffer words and response data.
- `ADDR_WIDTH`, 6, buffer address width (64-entry buffer).
- `clk`  in  1  single clock, all logic posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester read request valid; bit i = Ri.
- `req_addr0` / `req_addr1`  in  ADDR_WIDTH  request addresses.
- `req_ready`  out  2  request accepted this cycle; one-hot or zero.
- `rsp_valid`  out  2  response data available.
- `rsp_ready`  in  2  requester consumes response.
- `rsp_data0` / `rsp_data1`  out  DATA_WIDTH  FIFO head data.
- `buf_rd_en`  out  1  to buffer `rd_en`.
- `buf_rd_addr`  out  ADDR_WIDTH  to buffer `rd_addr`.
- `buf_data_out`  in  DATA_WIDTH  from buffer `data_out`.
- `buf_valid_out`  in  1  from buffer `valid_out`.
- `buf_wr_en`, `buf_wr_addr`, `buf_wr_data`  in  1/ADDR_WIDTH/DATA_WIDTH  snoop of the buffer write port.

## Operation
- Credit per requester i: `cnt_i = fifo_count_i + inflight_i - pop_i`, where `pop_i = rsp_valid[i] & rsp_ready[i]`. Ri is eligible when `req_valid[i]` and `cnt_i < 2`.
- Arbitration is combinational in the same cycle. With one eligible requester, it is granted. With both eligible, the requester that is not `last_grant` wins.
- `last_grant` updates on every grant. It resets to 1, so R0 wins the first tie.
- On grant g: `req_ready[g]=1`, `buf_rd_en=1`, and `buf_rd_addr=req_addr_g`. With no grant, `buf_rd_en=0` and `buf_rd_addr` holds its last value, which is don't-care.
- In-flight register `{if_valid, if_tag, if_fwd, if_fwd_data}` is loaded every cycle: `if_valid` = grant, `if_tag` = g.
- Capture cycle (`if_valid=1`): push `buf_data_out` (or `if_fwd_data`, see Configuration) into FIFO[if_tag].
  - `buf_valid_out` is checked only as an assertion; the push is gated by `if_valid` alone.
  - A `buf_valid_out` without `if_valid` (e.g. the cycle after reset) is ignored.
- Response FIFOs are 2 entries, in order, with registered head. `rsp_valid[i] = fifo_count_i != 0`.
- Push and pop in the same cycle on a FIFO is legal, and count is unchanged.
- Credit rule guarantees a FIFO never overflows. A push into a full FIFO is an assertion failure.
- No state machine beyond pointer/count/in-flight registers.

## Timing
- Request handshake at cycle t. Buffer read at t, data at t+1, FIFO push at end of t+1. `rsp_valid` is first high at t+2, so request-to-response latency is 2 cycles.
- Single requester with `rsp_ready` held 1: one grant per cycle, sustained.
- Both requesters active with `rsp_ready`=1: grants alternate R0,R1,R0,..., each requester at 1/2 rate.
- `rsp_ready[i]` held 0: Ri gets at most 2 grants, then `req_ready[i]=0` until a pop. The other requester is unaffected.
- Reset (any cycle, including mid-transfer):
  - Synchronous reset clears FIFOs, `if_valid`, and sets `last_grant=1`.
  - During `rst`: `req_ready=0`, `buf_rd_en=0`, `rsp_valid=0`.
  - Data in flight at reset is discarded.
- Reset values: `req_ready=0`, `rsp_valid=0`, `buf_rd_en=0`, `buf_rd_addr=0`, `rsp_data*=0`.

## Configuration
- `BUF_ARB_WR_FWD_EN` defined:
  - When the granted read address equals `buf_wr_addr` with `buf_wr_en=1` in the same cycle, set `if_fwd=1` and latch `buf_wr_data`.
  - The capture then pushes the latched write data, giving write-first semantics.
- Not defined: `if_fwd`/`if_fwd_data` are not built. The response carries the buffer's old contents, which is read-before-write behaviour.

## Test plan
- Single R0 stream of addrs 0..7, `rsp_ready`=1, buffer preloaded `mem[a]=a+100`:
  - `req_ready[0]` high every cycle.
  - `rsp_data0` = 100..107 on consecutive cycles starting 2 cycles after the first grant.
- R0 and R1 both request continuously from reset: grants are R0,R1,R0,R1. Each `rsp_dataN` matches its own addresses with no cross-routing.
- R1 `rsp_ready`=0 while both request:
  - R1 is granted exactly twice, then `req_ready[1]=0`, while R0 gets every cycle.
  - Raising `rsp_ready[1]` drains the 2 entries in order and R1 is re-granted in the same cycle as the first pop.
- Read addr 5 with a same-cycle write to 5 of 0xAAAA, old value 0x1234:
  - With `BUF_ARB_WR_FWD_EN`, the response is 0xAAAA.
  - Without it, the response is 0x1234.
- Assert `rst` for 1 cycle while both FIFOs are full and a read is in flight:
  - Next cycle `rsp_valid=0`, and the stale `buf_valid_out` push is suppressed.
  - The first post-reset tie is granted to R0.
